// File: rtl/can_rx_deframer_pkg.sv
// rtl/can_rx_deframer_pkg.sv - CAN 2.0A receive field widths, FSM states, error codes and CRC-15 step
package can_rx_deframer_pkg;

   localparam logic [14:0] CRC_POLY  = 15'h4599;
   localparam logic [2:0]  STUFF_RUN = 3'd5;

   // Last bit index of each multi-bit field, in field-counter width
   localparam logic [6:0] ID_LAST  = 7'd10;
   localparam logic [6:0] DLC_LAST = 7'd3;
   localparam logic [6:0] CRC_LAST = 7'd14;
   localparam logic [6:0] EOF_LAST = 7'd6;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ID,
      ST_RTR,
      ST_IDE,
      ST_R0,
      ST_DLC,
      ST_DATA,
      ST_CRC,
      ST_CRC_DEL,
      ST_ACK,
      ST_ACK_DEL,
      ST_EOF
   } rx_state_e;

   typedef enum logic [1:0] {
      ERR_STUFF = 2'b00,
      ERR_CRC   = 2'b01,
      ERR_FORM  = 2'b10,
      ERR_IDE   = 2'b11
   } rx_err_e;

   function automatic logic [14:0] crc15_next(input logic [14:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
   endfunction

endpackage

// File: rtl/can_rx_deframer_crc15.sv
// rtl/can_rx_deframer_crc15.sv - serial CRC-15 register, shared by the CAN RX deframer and TX framer
module can_crc15
   import can_rx_deframer_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic        din_i,
   output logic [14:0] crc_o
);

   logic [14:0] crc_q;
   logic [14:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc15_next(crc_q, din_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/can_rx_deframer.sv
// rtl/can_rx_deframer.sv - CAN 2.0A receive deframer: bus integration, destuffing, field parse, CRC and form checks
module can_rx_deframer
   import can_rx_deframer_pkg::*;
#(
   parameter int IDLE_BITS  = 11,
   parameter int DATA_BYTES = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    bit_en_i,
   input  logic                    rx_bit_i,
   output logic                    busy_o,
   output logic                    ack_req_o,
   output logic                    frame_valid_o,
   output logic                    frame_err_o,
   output logic [1:0]              err_code_o,
   output logic [10:0]             rx_id_o,
   output logic                    rx_rtr_o,
   output logic [3:0]              rx_dlc_o,
   output logic [8*DATA_BYTES-1:0] rx_data_o
);

   localparam int         DATA_W    = 8 * DATA_BYTES;
   localparam int         IDX_W     = $clog2(DATA_W);
   localparam logic [3:0] IDLE_CNT  = 4'(IDLE_BITS);
   localparam logic [3:0] MAX_BYTES = 4'(DATA_BYTES);

   rx_state_e          state_q, state_d;
   logic [6:0]         cnt_q, cnt_d;
   logic [2:0]         run_q, run_d;
   logic               last_q, last_d;
   logic [3:0]         rec_q, rec_d;
   logic [10:0]        id_q, id_d;
   logic               rtr_q, rtr_d;
   logic [3:0]         dlc_q, dlc_d;
   logic [6:0]         nbits_q, nbits_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic [14:0]        crc_rx_q, crc_rx_d;
   logic               crc_ok_q, crc_ok_d;
   logic               ack_q, ack_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [10:0]        rx_id_q, rx_id_d;
   logic               rx_rtr_q, rx_rtr_d;
   logic [3:0]         rx_dlc_q, rx_dlc_d;
   logic [DATA_W-1:0]  rx_data_q, rx_data_d;

   logic               crc_clear;
   logic               crc_en;
   logic [14:0]        crc_w;
   logic               err_hit;
   rx_err_e            err_sel;
   logic               destuff;
   logic [3:0]         dlc_next;
   logic [3:0]         nbytes;
   logic [IDX_W-1:0]   data_idx;
   logic [14:0]        crc_rx_next;

   can_crc15 u_crc (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (crc_clear),
      .en_i    (crc_en),
      .din_i   (rx_bit_i),
      .crc_o   (crc_w)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_d       = run_q;
      last_d      = last_q;
      rec_d       = rec_q;
      id_d        = id_q;
      rtr_d       = rtr_q;
      dlc_d       = dlc_q;
      nbits_d     = nbits_q;
      data_d      = data_q;
      crc_rx_d    = crc_rx_q;
      crc_ok_d    = crc_ok_q;
      ack_d       = 1'b0;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      err_code_d  = 2'b00;
      rx_id_d     = rx_id_q;
      rx_rtr_d    = rx_rtr_q;
      rx_dlc_d    = rx_dlc_q;
      rx_data_d   = rx_data_q;
      crc_clear   = 1'b0;
      crc_en      = 1'b0;
      err_hit     = 1'b0;
      err_sel     = ERR_STUFF;
      destuff     = state_q inside {ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC};
      dlc_next    = {dlc_q[2:0], rx_bit_i};
      data_idx    = IDX_W'(DATA_W - 1) - cnt_q[IDX_W-1:0];
      crc_rx_next = {crc_rx_q[13:0], rx_bit_i};

      if (rtr_q) begin
         nbytes = 4'd0;
      end else if (dlc_next > MAX_BYTES) begin
         nbytes = MAX_BYTES;
      end else begin
         nbytes = dlc_next;
      end

      if (bit_en_i) begin
         if (destuff && run_q == STUFF_RUN) begin
            // Stuff bit: must break the run, and is neither shifted nor CRC'd
            if (rx_bit_i == last_q) begin
               err_hit = 1'b1;
               err_sel = ERR_STUFF;
            end else begin
               last_d = rx_bit_i;
               run_d  = 3'd1;
            end
         end else begin
            if (destuff) begin
               if (rx_bit_i == last_q) begin
                  run_d = run_q + 3'd1;
               end else begin
                  run_d  = 3'd1;
                  last_d = rx_bit_i;
               end
            end
            case (state_q)
               ST_IDLE: begin
                  if (rx_bit_i) begin
                     if (rec_q != IDLE_CNT) rec_d = rec_q + 4'd1;
                  end else if (rec_q == IDLE_CNT) begin
                     state_d   = ST_ID;
                     cnt_d     = '0;
                     crc_clear = 1'b1;
                     last_d    = 1'b0;
                     run_d     = 3'd1;
                     data_d    = '0;
                     crc_ok_d  = 1'b0;
                     rec_d     = '0;
                  end else begin
                     rec_d = '0;
                  end
               end
               ST_ID: begin
                  crc_en = 1'b1;
                  id_d   = {id_q[9:0], rx_bit_i};
                  if (cnt_q == ID_LAST) begin
                     state_d = ST_RTR;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_RTR: begin
                  crc_en  = 1'b1;
                  rtr_d   = rx_bit_i;
                  state_d = ST_IDE;
               end
               ST_IDE: begin
                  crc_en = 1'b1;
                  if (rx_bit_i) begin
                     err_hit = 1'b1;
                     err_sel = ERR_IDE;
                  end else begin
                     state_d = ST_R0;
                  end
               end
               ST_R0: begin
                  crc_en  = 1'b1;
                  state_d = ST_DLC;
                  cnt_d   = '0;
               end
               ST_DLC: begin
                  crc_en = 1'b1;
                  dlc_d  = dlc_next;
                  if (cnt_q == DLC_LAST) begin
                     nbits_d = {nbytes, 3'b000};
                     cnt_d   = '0;
                     state_d = (nbytes == 4'd0) ? ST_CRC : ST_DATA;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_DATA: begin
                  // Bits land MSB-first so the first byte ends up in the top byte lane
                  crc_en           = 1'b1;
                  data_d[data_idx] = rx_bit_i;
                  if (cnt_q == nbits_q - 7'd1) begin
                     state_d = ST_CRC;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_CRC: begin
                  crc_rx_d = crc_rx_next;
                  if (cnt_q == CRC_LAST) begin
                     crc_ok_d = (crc_rx_next == crc_w);
                     state_d  = ST_CRC_DEL;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               ST_CRC_DEL: begin
                  if (!crc_ok_q) begin
                     err_hit = 1'b1;
                     err_sel = ERR_CRC;
                  end else if (!rx_bit_i) begin
                     err_hit = 1'b1;
                     err_sel = ERR_FORM;
                  end else begin
                     ack_d   = 1'b1;
                     state_d = ST_ACK;
                  end
               end
               ST_ACK: begin
                  state_d = ST_ACK_DEL;
               end
               ST_ACK_DEL: begin
                  if (!rx_bit_i) begin
                     err_hit = 1'b1;
                     err_sel = ERR_FORM;
                  end else begin
                     state_d = ST_EOF;
                     cnt_d   = '0;
                  end
               end
               ST_EOF: begin
                  if (!rx_bit_i) begin
                     err_hit = 1'b1;
                     err_sel = ERR_FORM;
                  end else if (cnt_q == EOF_LAST) begin
                     valid_d   = 1'b1;
                     rx_id_d   = id_q;
                     rx_rtr_d  = rtr_q;
                     rx_dlc_d  = dlc_q;
                     rx_data_d = data_q;
                     state_d   = ST_IDLE;
                     rec_d     = '0;
                  end else begin
                     cnt_d = cnt_q + 7'd1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end

      if (err_hit) begin
         err_d      = 1'b1;
         err_code_d = err_sel;
         state_d    = ST_IDLE;
         rec_d      = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         run_q      <= '0;
         last_q     <= 1'b0;
         rec_q      <= '0;
         id_q       <= '0;
         rtr_q      <= 1'b0;
         dlc_q      <= '0;
         nbits_q    <= '0;
         data_q     <= '0;
         crc_rx_q   <= '0;
         crc_ok_q   <= 1'b0;
         ack_q      <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'b00;
         rx_id_q    <= '0;
         rx_rtr_q   <= 1'b0;
         rx_dlc_q   <= '0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         run_q      <= run_d;
         last_q     <= last_d;
         rec_q      <= rec_d;
         id_q       <= id_d;
         rtr_q      <= rtr_d;
         dlc_q      <= dlc_d;
         nbits_q    <= nbits_d;
         data_q     <= data_d;
         crc_rx_q   <= crc_rx_d;
         crc_ok_q   <= crc_ok_d;
         ack_q      <= ack_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         rx_id_q    <= rx_id_d;
         rx_rtr_q   <= rx_rtr_d;
         rx_dlc_q   <= rx_dlc_d;
         rx_data_q  <= rx_data_d;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign ack_req_o     = ack_q;
   assign frame_valid_o = valid_q;
   assign frame_err_o   = err_q;
   assign err_code_o    = err_code_q;
   assign rx_id_o       = rx_id_q;
   assign rx_rtr_o      = rx_rtr_q;
   assign rx_dlc_o      = rx_dlc_q;
   assign rx_data_o     = rx_data_q;

endmodule

// File: tb/tb_can_rx_deframer.sv
// tb/tb_can_rx_deframer.sv - self-checking bench for can_rx_deframer with a frame encoder reference model
module tb_can_rx_deframer;

   logic        clk = 1'b0;
   logic        reset;
   logic        bit_en;
   logic        rx_bit;
   logic        busy, ack_req, frame_valid, frame_err;
   logic [1:0]  err_code;
   logic [10:0] rx_id;
   logic        rx_rtr;
   logic [3:0]  rx_dlc;
   logic [63:0] rx_data;

   int checks   = 0;
   int failures = 0;

   // Encoder output: unstuffed field bits, bus stream, and landmark indices in the stream
   bit raw_q[$];
   bit stream_q[$];
   int stuff_pos_q[$];
   int crc_del_idx;
   int eof_last_idx;
   int last_idx = -1;

   int          ack_cnt = 0, valid_cnt = 0, err_cnt = 0;
   int          ack_idx = -1, valid_idx = -1, err_idx = -1;
   logic [1:0]  err_code_seen = 2'b00;

   can_rx_deframer #(.IDLE_BITS(11), .DATA_BYTES(8)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .bit_en_i      (bit_en),
      .rx_bit_i      (rx_bit),
      .busy_o        (busy),
      .ack_req_o     (ack_req),
      .frame_valid_o (frame_valid),
      .frame_err_o   (frame_err),
      .err_code_o    (err_code),
      .rx_id_o       (rx_id),
      .rx_rtr_o      (rx_rtr),
      .rx_dlc_o      (rx_dlc),
      .rx_data_o     (rx_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ack_req) begin
         ack_cnt <= ack_cnt + 1;
         ack_idx <= last_idx;
      end
      if (frame_valid) begin
         valid_cnt <= valid_cnt + 1;
         valid_idx <= last_idx;
      end
      if (frame_err) begin
         err_cnt       <= err_cnt + 1;
         err_idx       <= last_idx;
         err_code_seen <= err_code;
      end
   end

   // Builds the bus bit stream of a frame; CRC is the polynomial remainder of M(x)*x^15 mod G(x).
   // flip_pos >= 0 inverts that unstuffed bit after the CRC was taken.
   task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                              input logic [63:0] data, input int flip_pos);
      int          n;
      int          run;
      bit          last;
      bit          work[$];
      logic [15:0] gen;
      logic [14:0] crc;
      raw_q.delete();
      stream_q.delete();
      stuff_pos_q.delete();
      raw_q.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
      raw_q.push_back(rtr);
      raw_q.push_back(1'b0);
      raw_q.push_back(1'b0);
      for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
      n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      for (int i = 0; i < n * 8; i++) raw_q.push_back(data[63-i]);
      gen  = 16'hC599;
      work = raw_q;
      for (int i = 0; i < 15; i++) work.push_back(1'b0);
      for (int i = 0; i < raw_q.size(); i++) begin
         if (work[i]) begin
            for (int j = 0; j < 16; j++) work[i+j] = work[i+j] ^ gen[15-j];
         end
      end
      for (int j = 0; j < 15; j++) crc[14-j] = work[raw_q.size()+j];
      if (flip_pos >= 0) raw_q[flip_pos] = ~raw_q[flip_pos];
      for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
      run  = 0;
      last = 1'b0;
      foreach (raw_q[i]) begin
         if (run == 5) begin
            stuff_pos_q.push_back(stream_q.size());
            stream_q.push_back(~last);
            last = ~last;
            run  = 1;
         end
         stream_q.push_back(raw_q[i]);
         if (run > 0 && raw_q[i] == last) begin
            run++;
         end else begin
            run  = 1;
            last = raw_q[i];
         end
      end
      crc_del_idx = stream_q.size();
      stream_q.push_back(1'b1);
      stream_q.push_back(1'($urandom_range(0, 1)));
      stream_q.push_back(1'b1);
      for (int i = 0; i < 7; i++) stream_q.push_back(1'b1);
      eof_last_idx = stream_q.size() - 1;
   endtask

   task automatic drive_bit(input bit b, input int idx);
      @(negedge clk);
      bit_en = 1'b1;
      rx_bit = b;
      @(posedge clk);
      #1;
      last_idx = idx;
      bit_en   = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         rx_bit = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_frame();
      repeat (11 + $urandom_range(0, 3)) drive_bit(1'b1, -1);
      foreach (stream_q[i]) drive_bit(stream_q[i], i);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      bit_en = 1'b0;
      rx_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({busy, ack_req, frame_valid, frame_err, err_code} !== 6'b0) begin
         failures++;
         $display("FAIL reset_pulses: got %b required 000000", {busy, ack_req, frame_valid, frame_err, err_code});
      end
      checks++;
      if ({rx_id, rx_rtr, rx_dlc, rx_data} !== 80'h0) begin
         failures++;
         $display("FAIL reset_fields: got id=%h rtr=%b dlc=%h data=%h required all zero", rx_id, rx_rtr, rx_dlc, rx_data);
      end
   endtask

   task automatic check_good(input string name, input logic [10:0] id, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data);
      int a0, v0, e0, n;
      logic [63:0] exp_data;
      a0 = ack_cnt; v0 = valid_cnt; e0 = err_cnt;
      build_frame(id, rtr, dlc, data, -1);
      send_frame();
      n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
      exp_data = '0;
      for (int i = 0; i < n * 8; i++) exp_data[63-i] = data[63-i];
      checks++;
      if (ack_cnt - a0 != 1 || ack_idx != crc_del_idx) begin
         failures++;
         $display("FAIL %s ack: got count=%0d at bit %0d required 1 at bit %0d", name, ack_cnt - a0, ack_idx, crc_del_idx);
      end
      checks++;
      if (valid_cnt - v0 != 1 || err_cnt != e0 || valid_idx != eof_last_idx) begin
         failures++;
         $display("FAIL %s valid: got valid=%0d err=%0d at bit %0d required 1 0 at bit %0d", name, valid_cnt - v0, err_cnt - e0, valid_idx, eof_last_idx);
      end
      checks++;
      if (rx_id !== id || rx_rtr !== rtr || rx_dlc !== dlc || rx_data !== exp_data) begin
         failures++;
         $display("FAIL %s fields: got id=%h rtr=%b dlc=%h data=%h required id=%h rtr=%b dlc=%h data=%h", name, rx_id, rx_rtr, rx_dlc, rx_data, id, rtr, dlc, exp_data);
      end
   endtask

   task automatic check_error(input string name, input logic [1:0] exp_code, input int exp_idx, input int exp_acks);
      int a0, v0, e0;
      logic [10:0] id0;
      logic [3:0]  dlc0;
      a0 = ack_cnt; v0 = valid_cnt; e0 = err_cnt;
      id0 = rx_id; dlc0 = rx_dlc;
      send_frame();
      checks++;
      if (err_cnt - e0 != 1 || err_code_seen !== exp_code || err_idx != exp_idx) begin
         failures++;
         $display("FAIL %s err: got count=%0d code=%b at bit %0d required 1 code=%b at bit %0d", name, err_cnt - e0, err_code_seen, err_idx, exp_code, exp_idx);
      end
      checks++;
      if (valid_cnt != v0 || ack_cnt - a0 != exp_acks) begin
         failures++;
         $display("FAIL %s pulses: got valid=%0d ack=%0d required 0 %0d", name, valid_cnt - v0, ack_cnt - a0, exp_acks);
      end
      checks++;
      if (rx_id !== id0 || rx_dlc !== dlc0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s hold: got id=%h dlc=%h busy=%b required id=%h dlc=%h busy=0", name, rx_id, rx_dlc, busy, id0, dlc0);
      end
   endtask

   task automatic test_basic_frame();
      check_good("basic", 11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
   endtask

   task automatic test_stuff_error();
      int pos;
      build_frame(11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, -1);
      checks++;
      if (stuff_pos_q.size() == 0) begin
         failures++;
         $display("FAIL stuff_present: got 0 stuff bits required at least 1");
      end else begin
         pos = stuff_pos_q[0];
         stream_q[pos] = ~stream_q[pos];
         check_error("stuff", 2'b00, pos, 0);
      end
      check_good("after_stuff", 11'h123, 1'b0, 4'd2, 64'hA55A_0000_0000_0000);
   endtask

   task automatic test_crc_error();
      build_frame(11'(($urandom)), 1'b0, 4'd2, {$urandom, $urandom}, 19 + int'($urandom_range(0, 15)));
      check_error("crc", 2'b01, crc_del_idx, 0);
   endtask

   task automatic test_rtr();
      check_good("rtr", 11'h7FF, 1'b1, 4'd4, 64'hDEAD_BEEF_0BAD_F00D);
   endtask

   task automatic test_dlc15();
      check_good("dlc15", 11'h2A5, 1'b0, 4'd15, 64'h0102_0304_0506_0708);
   endtask

   task automatic test_eof_form();
      build_frame(11'h456, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, -1);
      stream_q[eof_last_idx-3] = 1'b0;
      check_error("eof_form", 2'b10, eof_last_idx - 3, 1);
   endtask

   task automatic test_random_frames();
      for (int k = 0; k < 16; k++) begin
         check_good($sformatf("rand%0d", k), 11'($urandom), ($urandom_range(0, 3) == 0),
                    4'($urandom_range(0, 15)), {$urandom, $urandom});
      end
   endtask

   task automatic test_reset_mid_frame();
      int  a0, v0, e0;
      bit  saw_busy;
      a0 = ack_cnt; v0 = valid_cnt; e0 = err_cnt;
      build_frame(11'h5A3, 1'b0, 4'd3, {$urandom, $urandom}, -1);
      repeat (11) drive_bit(1'b1, -1);
      for (int i = 0; i < 6; i++) drive_bit(stream_q[i], i);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy: got %b required 1", busy);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || rx_id !== 11'h0 || rx_dlc !== 4'h0 || rx_data !== 64'h0) begin
         failures++;
         $display("FAIL mid_reset_state: got busy=%b id=%h dlc=%h data=%h required all zero", busy, rx_id, rx_dlc, rx_data);
      end
      @(negedge clk);
      reset = 1'b0;
      saw_busy = 1'b0;
      repeat (5) drive_bit(1'b1, -1);
      drive_bit(1'b0, -1);
      saw_busy |= busy;
      for (int i = 0; i < 4; i++) begin
         drive_bit(1'($urandom_range(0, 1)), -1);
         saw_busy |= busy;
      end
      checks++;
      if (saw_busy !== 1'b0) begin
         failures++;
         $display("FAIL short_idle_sof: got busy=1 required 0");
      end
      repeat (2) @(negedge clk);
      checks++;
      if (ack_cnt != a0 || valid_cnt != v0 || err_cnt != e0) begin
         failures++;
         $display("FAIL mid_reset_pulses: got ack=%0d valid=%0d err=%0d required 0 0 0", ack_cnt - a0, valid_cnt - v0, err_cnt - e0);
      end
      check_good("after_reset", 11'h0F0, 1'b0, 4'd8, {$urandom, $urandom});
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_stuff_error();
      test_crc_error();
      test_rtr();
      test_dlc15();
      test_eof_form();
      test_random_frames();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
